// File: rtl/if_stage_if.sv
// Bus between the instruction-fetch stage and its surroundings: hazard/redirect
// controls coming in, the instruction-memory port, and the IF/ID slot going out.
// The "slave" view belongs to if_stage; the "master" view belongs to whoever
// drives the controls and owns the memory.
interface if_stage_if #(
  parameter int PC_W = 15
);
  logic            stall_HZRD;
  logic            branch_EXE;
  logic            JAL_EXE;
  logic            JALR_EXE;
  logic [PC_W-1:0] branch_address_EXE;
  logic [PC_W-1:0] jalr_address_EXE;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [31:0]     instruction_IF_ID;
  logic [6:0]      OPCODE_IF_ID;
  logic [2:0]      FUNCT3_IF_ID;
  logic [4:0]      rd_IF_ID;
  logic [4:0]      rs1_IF_ID;
  logic [4:0]      rs2_IF_ID;
  logic [PC_W-1:0] pc_IF_ID;
  logic            valid_IF_ID;

  modport master (
    output stall_HZRD, branch_EXE, JAL_EXE, JALR_EXE,
           branch_address_EXE, jalr_address_EXE, imem_rdata,
    input  imem_addr, instruction_IF_ID, OPCODE_IF_ID, FUNCT3_IF_ID,
           rd_IF_ID, rs1_IF_ID, rs2_IF_ID, pc_IF_ID, valid_IF_ID
  );

  modport slave (
    input  stall_HZRD, branch_EXE, JAL_EXE, JALR_EXE,
           branch_address_EXE, jalr_address_EXE, imem_rdata,
    output imem_addr, instruction_IF_ID, OPCODE_IF_ID, FUNCT3_IF_ID,
           rd_IF_ID, rs1_IF_ID, rs2_IF_ID, pc_IF_ID, valid_IF_ID
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register. The PC drives a
// synchronous-read memory directly, so the word fetched for imem_addr lands in
// the IF/ID slot one edge later. Stalls freeze the slot by capturing the shown
// instruction (the memory keeps re-reading the next PC meanwhile); redirects
// load the target and squash the one wrong-path slot already in flight.
module if_stage #(
  parameter int          PC_W      = 15,
  parameter logic [14:0] RESET_PC  = 15'h0000,
  parameter int          PC_STEP   = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic     clk,
  input  logic     reset_n,
  if_stage_if.slave bus
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_pcIfId;
  logic            r_squashed;
  logic            r_holding;
  logic [31:0]     r_holdInstr;

  logic            w_redirect;
  logic [PC_W-1:0] w_target;
  logic [31:0]     w_instr;

  assign w_redirect = bus.branch_EXE | bus.JAL_EXE | bus.JALR_EXE;
  assign w_target   = bus.JALR_EXE ? bus.jalr_address_EXE : bus.branch_address_EXE;

  // Squashed slots always read as a NOP; a held slot replays the captured word.
  assign w_instr = r_squashed ? NOP_INSTR :
                   r_holding  ? r_holdInstr : bus.imem_rdata;

  assign bus.imem_addr         = r_pc;
  assign bus.instruction_IF_ID = w_instr;
  assign bus.OPCODE_IF_ID      = w_instr[6:0];
  assign bus.rd_IF_ID          = w_instr[11:7];
  assign bus.FUNCT3_IF_ID      = w_instr[14:12];
  assign bus.rs1_IF_ID         = w_instr[19:15];
  assign bus.rs2_IF_ID         = w_instr[24:20];
  assign bus.pc_IF_ID          = r_pcIfId;
  assign bus.valid_IF_ID       = ~r_squashed;

  // PC and IF/ID update: redirect beats stall, stall beats sequential fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc        <= PC_W'(RESET_PC);
      r_pcIfId    <= '0;
      r_squashed  <= 1'b1;
      r_holding   <= 1'b0;
      r_holdInstr <= NOP_INSTR;
    end else if (w_redirect) begin
      r_pc       <= w_target;
      r_pcIfId   <= r_pc;
      r_squashed <= 1'b1;
      r_holding  <= 1'b0;
    end else if (bus.stall_HZRD) begin
      r_holdInstr <= w_instr;
      r_holding   <= 1'b1;
    end else begin
      r_pc       <= r_pc + PC_W'(PC_STEP);
      r_pcIfId   <= r_pc;
      r_squashed <= 1'b0;
      r_holding  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a behavioural fetch model predicts each
// IF/ID slot when the stimulus is driven, queues it, and compares after the edge.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic        valid;
    logic [14:0] pc;
    logic [31:0] instr;
    logic [14:0] addr;
  } expect_t;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;

  expect_t     scoreboard[$];
  logic [14:0] mPc;
  expect_t     mCur;

  if_stage_if bus ();

  if_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: word 0 is the addi from the reset test, the rest encode their address.
  function automatic logic [31:0] memWord(input logic [14:0] addr);
    if (addr == 15'h0000) return 32'h00500093;
    return {addr, 2'b11, ~addr};
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) bus.imem_rdata <= memWord(bus.imem_addr);

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Compares every IF/ID output against one predicted slot.
  task automatic compareSlot(input expect_t e);
    checkOutput("valid",  32'(bus.valid_IF_ID),       32'(e.valid));
    checkOutput("pc",     32'(bus.pc_IF_ID),          32'(e.pc));
    checkOutput("instr",  bus.instruction_IF_ID,      e.instr);
    checkOutput("opcode", 32'(bus.OPCODE_IF_ID),      32'(e.instr[6:0]));
    checkOutput("funct3", 32'(bus.FUNCT3_IF_ID),      32'(e.instr[14:12]));
    checkOutput("rd",     32'(bus.rd_IF_ID),          32'(e.instr[11:7]));
    checkOutput("rs1",    32'(bus.rs1_IF_ID),         32'(e.instr[19:15]));
    checkOutput("rs2",    32'(bus.rs2_IF_ID),         32'(e.instr[24:20]));
    checkOutput("imem_addr", 32'(bus.imem_addr),      32'(e.addr));
  endtask

  // Drives one cycle of controls, predicts the resulting slot, then checks it after the edge.
  task automatic applyStimulus(input logic stall, input logic br, input logic jal,
                               input logic jalr, input logic [14:0] bAddr,
                               input logic [14:0] jAddr);
    expect_t e;
    bus.stall_HZRD         = stall;
    bus.branch_EXE         = br;
    bus.JAL_EXE            = jal;
    bus.JALR_EXE           = jalr;
    bus.branch_address_EXE = bAddr;
    bus.jalr_address_EXE   = jAddr;
    if (br || jal || jalr) begin
      e.valid = 1'b0;
      e.pc    = mPc;
      e.instr = NOP;
      mPc     = jalr ? jAddr : bAddr;
    end else if (stall) begin
      e = mCur;
    end else begin
      e.valid = 1'b1;
      e.pc    = mPc;
      e.instr = memWord(mPc);
      mPc     = mPc + 15'd4;
    end
    e.addr = mPc;
    mCur   = e;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    bus.stall_HZRD = 1'b0;
    bus.branch_EXE = 1'b0;
    bus.JAL_EXE    = 1'b0;
    bus.JALR_EXE   = 1'b0;
    if (scoreboard.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      compareSlot(scoreboard.pop_front());
    end
  endtask

  task automatic resetModel();
    mPc        = 15'h0000;
    mCur.valid = 1'b0;
    mCur.pc    = 15'h0000;
    mCur.instr = NOP;
    mCur.addr  = 15'h0000;
  endtask

  task automatic normal(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 15'h0, 15'h0);
  endtask

  initial begin
    logic [14:0] rAddr;
    compared   = 0;
    mismatched = 0;
    reset_n    = 1'b0;
    bus.stall_HZRD         = 1'b0;
    bus.branch_EXE         = 1'b0;
    bus.JAL_EXE            = 1'b0;
    bus.JALR_EXE           = 1'b0;
    bus.branch_address_EXE = '0;
    bus.jalr_address_EXE   = '0;
    resetModel();

    // Reset values while held in reset.
    #12;
    compareSlot(mCur);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // First fetch after reset, then sequential fetches up to pc 8.
    normal(1);
    checkOutput("t1_rd", 32'(bus.rd_IF_ID), 32'd1);
    normal(2);

    // Three stall cycles hold the slot at address 8, then 12 follows.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 15'h0, 15'h0);
    normal(1);
    checkOutput("t3_pc_after_stall", 32'(bus.pc_IF_ID), 32'd12);

    // Branch to 0x40: one squashed slot, then the target.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 15'h0040, 15'h0);
    normal(2);

    // JALR beats branch and stall together.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 15'h0040, 15'h0100);
    normal(1);
    checkOutput("t5_pc_jalr", 32'(bus.pc_IF_ID), 32'h100);

    // JAL, with a stall landing on the squashed slot.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 15'h0200, 15'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 15'h0, 15'h0);
    normal(2);

    // Wrap from the top of the address space.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 15'h7FF8, 15'h0);
    normal(2);
    checkOutput("t6_wrap_addr", 32'(bus.imem_addr), 32'h0);
    normal(1);

    // Random mix of stalls, branches and jumps.
    for (int i = 0; i < 60; i++) begin
      rAddr = 15'($urandom) & 15'h7FFC;
      case ($urandom_range(0, 7))
        0: applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, rAddr, 15'h0);
        1: applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 15'h0, rAddr);
        2, 3: applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, rAddr, rAddr);
        default: normal(1);
      endcase
    end

    // Asynchronous reset in the middle of a stall.
    normal(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 15'h0, 15'h0);
    #3;
    reset_n = 1'b0;
    #1;
    resetModel();
    compareSlot(mCur);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    normal(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
